// File: rtl/capture_buffer_reader_if.sv
// Bundle for the capture buffer read channel and the replayed I/Q sample stream.
// The master modport is the reader; the slave modport is the buffer plus the stream sink.
interface capture_buffer_reader_if #(
    parameter int unsigned CAP_INDEX_BITS = 10,
    parameter int unsigned CAP_I_BITS     = 12,
    parameter int unsigned CAP_Q_BITS     = 12
);
    logic        [CAP_INDEX_BITS-1:0] m_axi_cap_raddr;
    logic                             m_axi_cap_rvalid;
    logic                             s_axi_cap_rready;
    logic                             s_axi_cap_rvalid;
    logic                             m_axi_cap_rready;
    logic signed [CAP_I_BITS-1:0]     cap_i;
    logic signed [CAP_Q_BITS-1:0]     cap_q;
    logic signed [CAP_I_BITS-1:0]     out_i;
    logic signed [CAP_Q_BITS-1:0]     out_q;
    logic                             out_valid;
    logic                             out_ready;
    logic                             out_last;

    modport master (
        output m_axi_cap_raddr,
        output m_axi_cap_rvalid,
        input  s_axi_cap_rready,
        input  s_axi_cap_rvalid,
        output m_axi_cap_rready,
        input  cap_i,
        input  cap_q,
        output out_i,
        output out_q,
        output out_valid,
        input  out_ready,
        output out_last
    );

    modport slave (
        input  m_axi_cap_raddr,
        input  m_axi_cap_rvalid,
        output s_axi_cap_rready,
        output s_axi_cap_rvalid,
        input  m_axi_cap_rready,
        output cap_i,
        output cap_q,
        input  out_i,
        input  out_q,
        input  out_valid,
        output out_ready,
        input  out_last
    );
endinterface

// File: rtl/capture_buffer_reader.sv
// Sweeps capture buffer addresses with one read outstanding and replays samples via a 2-deep FIFO.
// Define CAP_READER_LOOP_EN for continuous passes that end on the pass during which stop was seen.
module capture_buffer_reader #(
    parameter int unsigned CAP_INDEX_BITS    = 10,
    parameter int unsigned CAP_BUFFER_LENGTH = 1024,
    parameter int unsigned CAP_I_BITS        = 12,
    parameter int unsigned CAP_Q_BITS        = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
`ifdef CAP_READER_LOOP_EN
    input  logic stop,
`endif
    output logic busy,
    output logic done,
    capture_buffer_reader_if.master bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int unsigned CNT_BITS   = CAP_INDEX_BITS + 1;
    localparam int unsigned ENTRY_BITS = CAP_I_BITS + CAP_Q_BITS + 2;
    localparam logic [CNT_BITS-1:0] LEN_CNT  = CNT_BITS'(CAP_BUFFER_LENGTH);
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(CAP_BUFFER_LENGTH - 1);

    logic [1:0]                state_q, state_d;
    logic [CAP_INDEX_BITS-1:0] raddr_q, raddr_d;
    logic [CNT_BITS-1:0]       issued_q, issued_d;
    logic                      outstanding_q, outstanding_d;
    logic                      pend_last_q, pend_last_d;
    logic                      pend_fin_q, pend_fin_d;
    logic                      done_q, done_d;

    // FIFO entry: {i, q, last, fin}; fin marks the beat that ends the whole run
    logic [ENTRY_BITS-1:0] fifo_q [2];
    logic                  fifo_wptr_q;
    logic                  fifo_rptr_q;
    logic [1:0]            fifo_count_q;

    logic                  req_valid;
    logic                  req_fire;
    logic                  rsp_fire;
    logic                  out_valid;
    logic                  pop_fire;
    logic                  issue_last;
    logic                  finishing;
    logic [ENTRY_BITS-1:0] head;
    logic                  head_last;
    logic                  head_fin;

`ifdef CAP_READER_LOOP_EN
    logic stop_seen_q;

    assign finishing = stop_seen_q || stop;

    always_ff @(posedge clk) begin
        if (reset) begin
            stop_seen_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            stop_seen_q <= 1'b0;
        end else if (stop) begin
            stop_seen_q <= 1'b1;
        end
    end
`else
    assign finishing = 1'b1;
`endif

    // Credit rule: a request only goes out when its response is guaranteed a FIFO slot
    assign req_valid  = (state_q == ST_RUN) && !outstanding_q && (fifo_count_q < 2'd2);
    assign req_fire   = req_valid && bus.s_axi_cap_rready;
    assign rsp_fire   = outstanding_q && bus.s_axi_cap_rvalid;
    assign out_valid  = (fifo_count_q != 2'd0);
    assign pop_fire   = out_valid && bus.out_ready;
    assign issue_last = (issued_q == LAST_CNT);

    assign head      = fifo_q[fifo_rptr_q];
    assign head_last = head[1];
    assign head_fin  = head[0];

    always_comb begin
        state_d       = state_q;
        raddr_d       = raddr_q;
        issued_d      = issued_q;
        outstanding_d = outstanding_q;
        pend_last_d   = pend_last_q;
        pend_fin_d    = pend_fin_q;
        done_d        = 1'b0;

        if (rsp_fire) begin
            outstanding_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    raddr_d  = '0;
                    issued_d = '0;
                end
            end
            ST_RUN: begin
                if (req_fire) begin
                    outstanding_d = 1'b1;
                    pend_last_d   = issue_last;
                    pend_fin_d    = issue_last && finishing;
`ifdef CAP_READER_LOOP_EN
                    if (issue_last) begin
                        raddr_d  = '0;
                        issued_d = '0;
                        if (finishing) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        raddr_d  = raddr_q + CAP_INDEX_BITS'(1);
                        issued_d = issued_q + CNT_BITS'(1);
                    end
`else
                    raddr_d  = raddr_q + CAP_INDEX_BITS'(1);
                    issued_d = issued_q + CNT_BITS'(1);
                    if (issued_d == LEN_CNT) begin
                        state_d = ST_DRAIN;
                    end
`endif
                end
            end
            ST_DRAIN: begin
                if (pop_fire && head_fin) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            raddr_q       <= '0;
            issued_q      <= '0;
            outstanding_q <= 1'b0;
            pend_last_q   <= 1'b0;
            pend_fin_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            raddr_q       <= raddr_d;
            issued_q      <= issued_d;
            outstanding_q <= outstanding_d;
            pend_last_q   <= pend_last_d;
            pend_fin_q    <= pend_fin_d;
            done_q        <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                fifo_q[k] <= '0;
            end
            fifo_wptr_q  <= 1'b0;
            fifo_rptr_q  <= 1'b0;
            fifo_count_q <= 2'd0;
        end else begin
            if (rsp_fire) begin
                fifo_q[fifo_wptr_q] <= {bus.cap_i, bus.cap_q, pend_last_q, pend_fin_q};
                fifo_wptr_q         <= ~fifo_wptr_q;
            end
            if (pop_fire) begin
                fifo_rptr_q <= ~fifo_rptr_q;
            end
            fifo_count_q <= fifo_count_q + {1'b0, rsp_fire} - {1'b0, pop_fire};
        end
    end

    assign bus.m_axi_cap_raddr  = raddr_q;
    assign bus.m_axi_cap_rvalid = req_valid;
    assign bus.m_axi_cap_rready = outstanding_q;
    assign bus.out_valid        = out_valid;
    assign bus.out_i = out_valid ? head[ENTRY_BITS-1 -: CAP_I_BITS] : '0;
    assign bus.out_q = out_valid ? head[2 +: CAP_Q_BITS] : '0;
    assign bus.out_last         = out_valid && head_last;

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

    credit_bound: assert property (@(posedge clk) disable iff (reset)
        ({1'b0, fifo_count_q} + {2'b00, outstanding_q}) <= 3'd2);

endmodule

// File: tb/tb_capture_buffer_reader.sv
// Randomized bench for capture_buffer_reader against a queue-based model of the sweep rules.
module tb_capture_buffer_reader;
    localparam int unsigned IB  = 3;
    localparam int unsigned LEN = 8;
    localparam int unsigned IW  = 12;
    localparam int unsigned QW  = 12;
`ifdef CAP_READER_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef struct packed {
        logic [IW-1:0] i;
        logic [QW-1:0] q;
        logic          last;
        logic          fin;
    } beat_t;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic start  = 1'b0;
    logic stop_v = 1'b0;
    logic busy;
    logic done;

    capture_buffer_reader_if #(.CAP_INDEX_BITS(IB), .CAP_I_BITS(IW), .CAP_Q_BITS(QW)) bus ();

    capture_buffer_reader #(
        .CAP_INDEX_BITS   (IB),
        .CAP_BUFFER_LENGTH(LEN),
        .CAP_I_BITS       (IW),
        .CAP_Q_BITS       (QW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
`ifdef CAP_READER_LOOP_EN
        .stop (stop_v),
`endif
        .busy (busy),
        .done (done),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Buffer image and model state
    logic [IW+QW-1:0] mem [LEN];
    beat_t q_m[$];
    bit    m_busy, m_done, m_out, m_issue_done, m_stop_seen, pend_fin;
    int    m_addr, pend_addr;
    bit    rsp_pending;
    int    rsp_delay;

    // Knobs
    int p_sready, p_oready, min_delay, max_delay;
    bit spurious, start_noise, start_req, rst_req;

    int checks, failures;
    int calls;
    int dut_beats, dut_lasts, dut_dones;
    int b0, l0, d0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        q_m.delete();
        m_busy = 0; m_done = 0; m_out = 0; m_issue_done = 0; m_stop_seen = 0;
        m_addr = 0; rsp_pending = 0; rsp_delay = 0; pend_fin = 0;
    endtask

    // One clock: check outputs against the model at negedge, drive inputs, advance the model.
    task automatic cycle();
        bit    exp_rvalid, sready, srvalid, oready, req_f, rsp_f, pop_f, start_f, lst;
        beat_t hd, nb;
        @(negedge clk);
        calls++;
        exp_rvalid = m_busy && !m_issue_done && !m_out && (q_m.size() < 2);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("m_axi_cap_rvalid", bus.m_axi_cap_rvalid, exp_rvalid);
        chk("m_axi_cap_rready", bus.m_axi_cap_rready, m_out);
        chk("out_valid", bus.out_valid, q_m.size() != 0);
        if (exp_rvalid) chk("raddr", bus.m_axi_cap_raddr, m_addr);
        if (q_m.size() != 0) begin
            hd = q_m[0];
            chk("out_i", $unsigned(bus.out_i), hd.i);
            chk("out_q", $unsigned(bus.out_q), hd.q);
            chk("out_last", bus.out_last, hd.last);
        end
        if (done) dut_dones++;

        sready  = ($urandom_range(99) < p_sready);
        oready  = ($urandom_range(99) < p_oready);
        srvalid = 1'b0;
        bus.cap_i = IW'($urandom);
        bus.cap_q = QW'($urandom);
        if (rsp_pending) begin
            if (rsp_delay == 0) begin
                srvalid = 1'b1;
                {bus.cap_i, bus.cap_q} = mem[pend_addr];
            end else begin
                rsp_delay--;
            end
        end else if (spurious) begin
            srvalid = ($urandom_range(1) == 1);
        end
        reset = rst_req;
        start = start_req || (start_noise && m_busy && ($urandom_range(3) == 0));
        start_req = 1'b0;
        bus.s_axi_cap_rready = sready;
        bus.s_axi_cap_rvalid = srvalid;
        bus.out_ready        = oready;
        if (bus.out_valid && oready) begin
            dut_beats++;
            if (bus.out_last) dut_lasts++;
        end
        if (rst_req) begin
            model_clear();
            return;
        end

        req_f   = exp_rvalid && sready;
        rsp_f   = m_out && srvalid;
        pop_f   = (q_m.size() != 0) && oready;
        start_f = !m_busy && start;
        m_done  = 0;
        if (pop_f) begin
            hd = q_m.pop_front();
            if (hd.fin) begin
                m_busy = 0;
                m_done = 1;
            end
        end
        if (rsp_f) begin
            nb.i    = mem[pend_addr][IW+QW-1:QW];
            nb.q    = mem[pend_addr][QW-1:0];
            nb.last = (pend_addr == LEN - 1);
            nb.fin  = pend_fin;
            q_m.push_back(nb);
            m_out = 0;
            rsp_pending = 0;
        end
        if (req_f) begin
            lst         = (m_addr == LEN - 1);
            m_out       = 1;
            rsp_pending = 1;
            pend_addr   = m_addr;
            rsp_delay   = $urandom_range(max_delay, min_delay);
            pend_fin    = lst && (!LOOP || m_stop_seen || stop_v);
            if (pend_fin) m_issue_done = 1;
            m_addr = lst ? 0 : m_addr + 1;
        end
        if (m_busy && stop_v) m_stop_seen = 1;
        if (start_f) begin
            m_busy = 1; m_issue_done = 0; m_addr = 0; m_stop_seen = 0;
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, " busy"}, busy, 1'b0);
        chk({name, " done"}, done, 1'b0);
        chk({name, " rvalid"}, bus.m_axi_cap_rvalid, 1'b0);
        chk({name, " rready"}, bus.m_axi_cap_rready, 1'b0);
        chk({name, " raddr"}, bus.m_axi_cap_raddr, 0);
        chk({name, " out_valid"}, bus.out_valid, 1'b0);
        chk({name, " out_i"}, $unsigned(bus.out_i), 0);
        chk({name, " out_q"}, $unsigned(bus.out_q), 0);
        chk({name, " out_last"}, bus.out_last, 1'b0);
    endtask

    task automatic begin_sweep();
        start_req = 1; calls = 0;
        b0 = dut_beats; l0 = dut_lasts; d0 = dut_dones;
    endtask

    task automatic finish_sweep(input string name, input int exp_beats, input int exp_lasts,
                                input int bound);
        for (int c = 0; c < bound && !m_done; c++) cycle();
        chk({name, " finished in bound"}, m_done, 1'b1);
        cycle();
        chk({name, " beats"}, dut_beats - b0, exp_beats);
        chk({name, " last beats"}, dut_lasts - l0, exp_lasts);
        chk({name, " done pulses"}, dut_dones - d0, 1);
    endtask

    task automatic nominal();
        p_sready = 100; p_oready = 100; min_delay = 0; max_delay = 0;
        spurious = 0; start_noise = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        checks = 0; failures = 0; calls = 0;
        dut_beats = 0; dut_lasts = 0; dut_dones = 0;
        start_req = 0; rst_req = 0;
        stop_v = LOOP;
        for (int k = 0; k < LEN; k++) mem[k] = (IW + QW)'($urandom);
        model_clear();
        nominal();
        bus.s_axi_cap_rready = 0; bus.s_axi_cap_rvalid = 0; bus.out_ready = 0;
        bus.cap_i = '0; bus.cap_q = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");

        // 1: nominal sweep; last pop lands 18 clocks after start is driven
        begin_sweep();
        for (int c = 0; c < 100 && !m_done; c++) cycle();
        n = calls;
        chk("t1 start-to-done clocks", n, 18);
        cycle();
        chk("t1 beats", dut_beats - b0, LEN);
        chk("t1 last beats", dut_lasts - l0, 1);
        chk("t1 done pulses", dut_dones - d0, 1);
        chk("t1 busy after done", busy, 1'b0);

        // 2: downstream stall mid-sweep fills the FIFO and blocks requests
        begin_sweep();
        for (int c = 0; c < 100 && dut_beats - b0 < 2; c++) cycle();
        p_oready = 0;
        repeat (5) cycle();
        chk("t2 stall rvalid", bus.m_axi_cap_rvalid, 1'b0);
        chk("t2 stall out_valid", bus.out_valid, 1'b1);
        chk("t2 model fill", q_m.size(), 2);
        p_oready = 100;
        finish_sweep("t2", LEN, 1, 200);

        // 3: request refused for 3 clocks, then every response delayed 4 clocks
        p_sready = 0; min_delay = 4; max_delay = 4;
        begin_sweep();
        repeat (4) cycle();
        chk("t3 rvalid held", bus.m_axi_cap_rvalid, 1'b1);
        chk("t3 raddr held", bus.m_axi_cap_raddr, 0);
        p_sready = 100;
        finish_sweep("t3", LEN, 1, 300);

        // 4: start noise while busy and spurious responses while nothing is outstanding
        nominal(); spurious = 1; start_noise = 1;
        begin_sweep();
        finish_sweep("t4", LEN, 1, 300);
        b0 = dut_beats;
        repeat (10) cycle();
        chk("t4 idle beats", dut_beats - b0, 0);
        chk("t4 idle busy", busy, 1'b0);

        // 5: reset after 3 beats aborts; restart sweeps from address 0
        nominal();
        begin_sweep();
        for (int c = 0; c < 100 && dut_beats - b0 < 3; c++) cycle();
        spurious = 1; rst_req = 1;
        cycle();
        rst_req = 0;
        @(posedge clk);
        #1;
        chk_zero("t5 after reset");
        spurious = 0;
        begin_sweep();
        finish_sweep("t5 restart", LEN, 1, 300);

        // Randomized sweeps
        for (int s = 0; s < 8; s++) begin
            p_sready = $urandom_range(100, 30); p_oready = $urandom_range(100, 30);
            min_delay = 0; max_delay = $urandom_range(3);
            spurious = $urandom_range(1) == 1; start_noise = $urandom_range(1) == 1;
            begin_sweep();
            finish_sweep("random", LEN, 1, 2000);
        end

`ifdef CAP_READER_LOOP_EN
        // 6: looping; stop pulsed during the second pass ends after that pass
        nominal(); stop_v = 0;
        begin_sweep();
        for (int c = 0; c < 300 && dut_beats - b0 < LEN + 1; c++) cycle();
        stop_v = 1;
        cycle();
        stop_v = 0;
        finish_sweep("t6 loop", 2 * LEN, 2, 600);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
